// File: rtl/test_monitor_pkg.sv
// rtl/test_monitor_pkg.sv - shared state encoding and default addresses for the test monitor
package test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } tm_state_e;

  localparam logic [31:0] DEFAULT_DONE_PC     = 32'h0000_0044;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/tm_cycle_counter.sv
// rtl/tm_cycle_counter.sv - saturating run-cycle counter with expiry flag one short of the limit
module tm_cycle_counter #(
  parameter int LIMIT = 6000,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CNT_W'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted during the last budgeted cycle so the move to TIMEOUT lands on the LIMIT-th edge.
  assign expired = (count_q == CNT_W'(LIMIT - 1));
  assign count   = count_q;

endmodule

// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - watches a core for test completion via done-PC, tohost store or timeout
// Optional tohost mailbox detection is enabled by defining TEST_MONITOR_TOHOST_EN.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int               XLEN           = 32,
  parameter logic [XLEN-1:0]  DONE_PC        = XLEN'(DEFAULT_DONE_PC),
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR),
  parameter int               TIMEOUT_CYCLES = 6000,
  localparam int              CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  gp_value,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             done,
  output logic [XLEN-2:0]  fail_num,
  output logic [CNT_W-1:0] cycle_count
);

  tm_state_e       state_q, state_d;
  logic [XLEN-2:0] fail_num_q, fail_num_d;
  logic            busy_q, pass_q, fail_q, timeout_q, done_q;
  logic            busy_d, pass_d, fail_d, timeout_d, done_d;
  logic            pc_hit, tohost_hit, cnt_clr, cnt_en, cnt_expired;

  assign pc_hit = pc_valid && (pc == DONE_PC);

`ifdef TEST_MONITOR_TOHOST_EN
  assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
`else
  logic unused_st;
  assign unused_st  = ^{st_valid, st_addr, st_data};
  assign tohost_hit = 1'b0;
`endif

  assign cnt_clr = clear || ((state_q == ST_IDLE) && start);
  assign cnt_en  = (state_q == ST_RUN) && !clear;

  tm_cycle_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cycle_count),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fail_num_q <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_num_q <= fail_num_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  // Priority inside RUN: tohost store, then done-PC, then budget expiry.
  always_comb begin
    state_d    = state_q;
    fail_num_d = fail_num_q;
    if (clear) begin
      state_d    = ST_IDLE;
      fail_num_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_RUN;
            fail_num_d = '0;
          end
        end
        ST_RUN: begin
          if (tohost_hit) begin
            if (st_data == XLEN'(1)) begin
              state_d = ST_PASS;
            end else begin
              state_d    = ST_FAIL;
              fail_num_d = st_data[XLEN-1:1];
            end
          end else if (pc_hit) begin
            if (gp_value == XLEN'(1)) begin
              state_d = ST_PASS;
            end else begin
              state_d    = ST_FAIL;
              fail_num_d = gp_value[XLEN-1:1];
            end
          end else if (cnt_expired) begin
            state_d = ST_TIMEOUT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy_d    = (state_d == ST_RUN);
    pass_d    = (state_d == ST_PASS);
    fail_d    = (state_d == ST_FAIL);
    timeout_d = (state_d == ST_TIMEOUT);
    done_d    = pass_d || fail_d || timeout_d;
  end

  assign busy     = busy_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign done     = done_q;
  assign fail_num = fail_num_q;

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DONE_PC, default 32'h44, fetch PC that marks test completion.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h1000, store address of tohost mailbox.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 6000, cycle budget before timeout; CNT_W = $clog2(TIMEOUT_CYCLES+1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 start  input  1  one-cycle pulse, arms monitor from IDLE.
REQ-008 clear  input  1  returns monitor to IDLE from any state.
REQ-009 pc_valid  input  1  qualifies pc.
REQ-010 pc  input  XLEN  core fetch PC.
REQ-011 gp_value  input  XLEN  live value of register x3.
REQ-012 st_valid  input  1  qualifies store bus.
REQ-013 st_addr  input  XLEN  store address.
REQ-014 st_data  input  XLEN  store data.
REQ-015 busy / pass / fail / timeout  output  1 each  status, mutually exclusive.
REQ-016 done  output  1  pass|fail|timeout.
REQ-017 fail_num  output  XLEN-1  failing test number.
REQ-018 cycle_count  output  CNT_W  cycles spent in RUN.

Function
REQ-019 SHALL implement states IDLE, RUN, PASS, FAIL, TIMEOUT.
REQ-020 IDLE->RUN on start; start outside IDLE SHALL be ignored.
REQ-021 In RUN, pc_valid && pc==DONE_PC SHALL go to PASS if gp_value==1, else FAIL with fail_num=gp_value>>1.
REQ-022 In RUN, with tohost enabled, st_valid && st_addr==TOHOST_ADDR && st_data[0]==1 SHALL go to PASS if st_data==1, else FAIL with fail_num=st_data>>1; st_data[0]==0 SHALL be ignored.
REQ-023 Tohost event and PC event in same cycle: tohost SHALL win.
REQ-024 cycle_count SHALL clear on IDLE->RUN, increment each RUN cycle, saturate, and freeze in terminal states.
REQ-025 RUN->TIMEOUT when cycle_count==TIMEOUT_CYCLES-1 and no completion event that cycle; completion in same cycle SHALL win.
REQ-026 Outputs SHALL be registered: status visible the cycle after the triggering edge (latency 1).
REQ-027 PASS/FAIL/TIMEOUT SHALL be sticky until clear or rst; clear SHALL win over start and every event in the same cycle.

Reset
REQ-028 rst SHALL force IDLE, all status outputs 0, fail_num 0, cycle_count 0, asynchronously; reset mid-RUN discards progress.

Configuration
REQ-029 With TEST_MONITOR_TOHOST_EN defined, REQ-022/023 SHALL be active; without it st_* SHALL be ignored and only PC match and timeout complete a run.

Structure
REQ-030 Package test_monitor_pkg SHALL hold the state enum and default TOHOST_ADDR/DONE_PC constants.
REQ-031 Saturating run counter SHALL be sub-module tm_cycle_counter (inputs clr, en; output count, expired).

Verification
REQ-032 start; after 20 cycles pc=0x44, gp=1 -> pass=1 next cycle, cycle_count=20, stays until clear.
REQ-033 start; pc=0x44, gp=7 -> fail=1, fail_num=3.
REQ-034 TOHOST_EN: store 0x1000 data 0x0B same cycle as pc=0x44 gp=1 -> fail=1, fail_num=5; store data 0x2 -> ignored.
REQ-035 TIMEOUT_CYCLES=16, no events -> timeout=1 after 16 RUN cycles; pc=0x44,gp=1 on cycle 15 -> pass instead.
REQ-036 rst pulse asynchronously mid-RUN -> all outputs 0 immediately; clear+start same cycle in PASS -> IDLE.
